fcc_req_arbiter: RTL
====================

# fcc_req_arbiter

Round-robin arbiter that shares the single-channel 264-bit request entry interface of the flash channel controller among REQ_NUM host submission sources. Sits in the clk (XDMA) domain, upstream of the wrapper's request FIFO port. It stamps the source index into the upper CID bits and limits outstanding commands per source. Completions returned by CID decrement the per-source outstanding count.

## Interface
Parameters:
- REQ_NUM, 4, number of requesters; power of two, 2..8.
- MAX_OUT, 8, maximum outstanding commands per requester; 1..255.
- IDX_W, $clog2(REQ_NUM), derived width of the source index.
- CNT_W, $clog2(MAX_OUT+1), derived width of the outstanding counter.

Ports:
- clk  in  1  single clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- s_req_valid  in  REQ_NUM  per-requester entry valid.
- s_req_ready  out  REQ_NUM  per-requester accept; one-hot or zero.
- s_req_data  in  REQ_NUM*264  per-requester entries; requester i occupies bits [264*i +: 264].
- m_req_valid  out  1  entry valid toward the request FIFO.
- m_req_ready  in  1  request FIFO ready.
- m_req_data  out  264  granted entry with CID stamped.
- m_req_src  out  IDX_W  index of the source of m_req_data.
- i_cpl_valid  in  1  completion pulse, one per finished command.
- i_cpl_cid  in  16  CID of the completed command.
- o_outstanding  out  REQ_NUM*CNT_W  per-requester outstanding count.
- o_cpl_err  out  1  sticky flag: a completion arrived for a requester whose count was zero.
- o_grant_cnt  out  REQ_NUM*32  per-requester grant counters; present only under FCC_ARB_STATS_EN.

## Operation
- Eligibility of requester i: s_req_valid[i] is high and outstanding[i] < MAX_OUT.
- Load condition: load = !m_req_valid || m_req_ready.
- Grant:
  - On load with at least one eligible requester, pick the first eligible index searching upward from last_grant+1, with wrap-around.
  - Assert s_req_ready for that index only, in the same cycle.
  - Register the entry into m_req_data, stamp the source, set m_req_valid, and update last_grant.
- CID stamp: m_req_data[31:32-IDX_W] = granted index. All other bits pass through unchanged. Sources must keep their CIDs below 2^(16-IDX_W).
- On load with no eligible requester, m_req_valid falls (or stays) low.
- Output register: m_req_valid, m_req_data and m_req_src stay stable while m_req_valid && !m_req_ready.
- Outstanding count, requester i:
  - Increments on a grant to i.
  - Decrements on i_cpl_valid when i_cpl_cid[15:16-IDX_W] == i.
  - Grant and completion in the same cycle for the same i: count unchanged.
  - A completion against a zero count is ignored, and o_cpl_err sets. o_cpl_err clears only on reset.
- The grant decision uses the registered count. A completion arriving in the same cycle does not make a full requester eligible until the next cycle.

## Timing
- Reset values: m_req_valid=0, m_req_data=0, m_req_src=0, s_req_ready=0, all counts 0, o_cpl_err=0, last_grant=REQ_NUM-1 (so requester 0 wins first), o_grant_cnt=0.
- Latency: an s_req handshake in cycle N puts the entry on m_req in cycle N+1.
- Throughput: one entry per cycle while m_req_ready stays high.
- s_req_ready is combinational from the registered state, s_req_valid and m_req_ready. There is no combinational path from m_req_data.
- Reset asserted mid-transfer drops m_req_valid immediately. The in-flight entry is lost and the counts are cleared.
- Fairness: with all requesters continuously eligible, grants follow 0,1,…,REQ_NUM-1,0,… and no requester waits more than REQ_NUM-1 grants.

## Configuration
- FCC_ARB_STATS_EN:
  - When defined: per-requester 32-bit grant counters that increment on each grant, wrap at 2^32 and reset to 0.
  - When undefined: o_grant_cnt is tied to 0 and no counter registers are built.

## Structure
- Package fcc_arb_pkg holds:
  - REQ_ENTRY_W=264
  - CID_LSB=16, CID_MSB=31
  - OPC_LSB=0, OPC_MSB=15
  - typedef req_entry_t (logic [263:0])
- Sub-module fcc_rr_picker: combinational rotate-priority encoder.
  - Inputs: eligible mask and last_grant.
  - Outputs: grant one-hot, grant index and any-grant flag.
  - Instantiated once.

## Test plan
- After reset, all 4 requesters valid with distinct CIDs and m_req_ready=1 -> grants in order 0,1,2,3,0; m_req_data[31:30] = 0,1,2,3,0.
- Requester 2 issues 8 requests with MAX_OUT=8 and no completions -> the 9th is held (s_req_ready[2]=0); one completion with CID 0x8005 releases it the next cycle.
- m_req_ready=0 for 5 cycles with m_req_valid high -> m_req_data and m_req_src stay stable, all s_req_ready=0.
- Grant to requester 1 and completion CID 0x4001 in the same cycle -> o_outstanding[1] unchanged.
- Completion with CID 0xC000 while count[3]=0 -> o_cpl_err=1 and stays 1; all counts unchanged.
- Under FCC_ARB_STATS_EN, 10 grants to requester 0 then rst_n pulsed low mid-transfer -> o_grant_cnt[0]=10 before reset; after reset all counters and m_req_valid are 0.

Source files
------------

// File: rtl/fcc_arb_pkg.sv
// Shared constants and types for the flash channel controller request arbiter.
// Holds the 264-bit request entry layout (CID and opcode field positions).
// No logic; imported by the arbiter top.
package fcc_arb_pkg;

  localparam int REQ_ENTRY_W = 264;
  localparam int CID_LSB     = 16;
  localparam int CID_MSB     = 31;
  localparam int OPC_LSB     = 0;
  localparam int OPC_MSB     = 15;

  typedef logic [REQ_ENTRY_W-1:0] req_entry_t;

endpackage

// File: rtl/fcc_rr_picker.sv
// Rotating-priority encoder: first eligible index searching upward from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module fcc_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] cand;

  // Walk the ring starting just after the previous winner; N is a power of two so index math wraps for free
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_grant + IDX_W'(k);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_oh = gnt_any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/fcc_req_arbiter.sv
// Round-robin arbiter sharing the 264-bit request entry port among REQ_NUM sources, CID stamped with source index.
// Latency: one cycle from s_req handshake to m_req_valid (registered output stage).
// Backpressure: s_req_ready only when the output register can load; per-source outstanding limit MAX_OUT.
// Optional FCC_ARB_STATS_EN builds per-source 32-bit grant counters; otherwise o_grant_cnt is tied to zero.
module fcc_req_arbiter
  import fcc_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int MAX_OUT = 8,
  parameter int IDX_W   = $clog2(REQ_NUM),
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           s_req_valid,
  output logic [REQ_NUM-1:0]           s_req_ready,
  input  logic [REQ_NUM*REQ_ENTRY_W-1:0] s_req_data,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output req_entry_t                   m_req_data,
  output logic [IDX_W-1:0]             m_req_src,
  input  logic                         i_cpl_valid,
  input  logic [15:0]                  i_cpl_cid,
  output logic [REQ_NUM*CNT_W-1:0]     o_outstanding,
  output logic                         o_cpl_err,
  output logic [REQ_NUM*32-1:0]        o_grant_cnt
);

  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt [REQ_NUM];
  logic [REQ_NUM-1:0] eligible;
  logic [REQ_NUM-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               load;
  logic               grant;
  logic [REQ_NUM-1:0] inc_vec;
  logic [REQ_NUM-1:0] dec_vec;
  logic [IDX_W-1:0]   cpl_idx;
  logic               cpl_on_zero;
  req_entry_t         sel_entry;

  // A source competes only while it has room under its outstanding limit (registered count)
  always_comb begin
    eligible = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      eligible[i] = s_req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  assign load        = !m_req_valid || m_req_ready;
  assign grant       = load && gnt_any;
  assign s_req_ready = grant ? gnt_oh : '0;

  fcc_rr_picker #(
    .N     (REQ_NUM),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .gnt_oh     (gnt_oh),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Completion source lives in the top IDX_W bits of the CID
  assign cpl_idx     = IDX_W'(i_cpl_cid >> (16 - IDX_W));
  assign cpl_on_zero = i_cpl_valid && (cnt[cpl_idx] == '0);

  // Select the winning entry and overwrite the upper CID bits with its source index
  always_comb begin
    sel_entry = s_req_data[REQ_ENTRY_W*gnt_idx +: REQ_ENTRY_W];
    sel_entry[CID_MSB -: IDX_W] = gnt_idx;
  end

  // Per-source increment/decrement requests; a completion against an empty count is dropped
  always_comb begin
    inc_vec = grant ? gnt_oh : '0;
    dec_vec = '0;
    if (i_cpl_valid && !cpl_on_zero) begin
      dec_vec[cpl_idx] = 1'b1;
    end
  end

  // Output register stage: holds while the downstream FIFO stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_valid <= 1'b0;
      m_req_data  <= '0;
      m_req_src   <= '0;
      last_grant  <= IDX_W'(REQ_NUM - 1);
    end else if (load) begin
      m_req_valid <= gnt_any;
      if (gnt_any) begin
        m_req_data <= sel_entry;
        m_req_src  <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

  // Outstanding counters: grant and completion in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Sticky error: a completion arrived for a source with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cpl_err <= 1'b0;
    end else if (cpl_on_zero) begin
      o_cpl_err <= 1'b1;
    end
  end

  // Flatten the counter array onto the status port
  always_comb begin
    o_outstanding = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      o_outstanding[CNT_W*i +: CNT_W] = cnt[i];
    end
  end

`ifdef FCC_ARB_STATS_EN
  logic [31:0] gcnt [REQ_NUM];

  // Free-running per-source grant counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        gcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (inc_vec[i]) begin
          gcnt[i] <= gcnt[i] + 32'd1;
        end
      end
    end
  end

  // Flatten grant counters onto the status port
  always_comb begin
    o_grant_cnt = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      o_grant_cnt[32*i +: 32] = gcnt[i];
    end
  end
`else
  assign o_grant_cnt = '0;
`endif

endmodule
